// File: rtl/ftdi_async_bridge.sv
// FTDI FT245-style asynchronous FIFO bridge.
// Holds a host-side write queue and read queue and moves bytes to and from the
// FTDI chip with timed ftdi_wr / ftdi_rd strobes, alternating direction when
// both are ready.
module ftdi_async_bridge #(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WR_SETUP_CYC = 1,
  parameter int unsigned WR_LOW_CYC   = 2,
  parameter int unsigned RD_LOW_CYC   = 2,
  parameter int unsigned GAP_CYC      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  txe,
  input  logic                  rxf,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  wrreq,
  input  logic [7:0]            data_wr,
  input  logic                  rdreq,
  input  logic [7:0]            adbus_in,
  output logic [7:0]            adbus_out,
  output logic                  adbus_tri,
  output logic                  ftdi_wr,
  output logic                  ftdi_rd,
  output logic [7:0]            data_rd,
  output logic                  rdq_full,
  output logic                  rdq_empty,
  output logic                  wrq_full,
  output logic                  wrq_empty,
  output logic [DEPTH_LOG2:0]   rd_qsize,
  output logic [DEPTH_LOG2:0]   wr_qsize
);

  localparam int unsigned        DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]        WS_LAST  = 16'(WR_SETUP_CYC - 1);
  localparam logic [15:0]        WL_LAST  = 16'(WR_LOW_CYC - 1);
  localparam logic [15:0]        RL_LAST  = 16'(RD_LOW_CYC - 1);
  localparam logic [15:0]        GP_LAST  = 16'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_LOW, RD_LOW, GAP} state_t;
  typedef enum logic {DIR_WR, DIR_RD} dir_t;

  state_t      state, state_nx;
  dir_t        last_dir;
  logic [15:0] cnt;
  logic        fsm_pop, fsm_cap;
  logic        rd_elig, wr_elig;

  // ---------------- status synchronisers ----------------
  logic [SYNC_STAGES-1:0] txe_sync, rxf_sync;
  logic                   txe_s, rxf_s;

  // Shift the asynchronous FTDI status lines through the synchroniser chain
  always_ff @(posedge clock) begin
    if (reset) begin
      txe_sync <= '1;
      rxf_sync <= '1;
    end else begin
      txe_sync <= {txe_sync[SYNC_STAGES-2:0], txe};
      rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], rxf};
    end
  end

  assign txe_s = txe_sync[SYNC_STAGES-1];
  assign rxf_s = rxf_sync[SYNC_STAGES-1];

  // ---------------- write queue (host -> FTDI) ----------------
  logic [7:0]            wq_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wq_rp, wq_wp;
  logic [DEPTH_LOG2:0]   wq_cnt;
  logic                  wq_push, wq_pop;

  assign wrq_full  = (wq_cnt == FULL_CNT);
  assign wrq_empty = (wq_cnt == '0);
  assign wr_qsize  = wq_cnt;
  assign wq_pop    = fsm_pop & ~clear & ~wrq_empty;
  // A push while full is accepted only when a pop frees the slot in the same cycle
  assign wq_push   = wrreq & ~clear & ~reset & (~wrq_full | wq_pop);

  // Write-queue pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wq_rp  <= '0;
      wq_wp  <= '0;
      wq_cnt <= '0;
    end else begin
      if (wq_push) wq_wp <= wq_wp + 1'b1;
      if (wq_pop)  wq_rp <= wq_rp + 1'b1;
      unique case ({wq_push, wq_pop})
        2'b10:   wq_cnt <= wq_cnt + 1'b1;
        2'b01:   wq_cnt <= wq_cnt - 1'b1;
        default: wq_cnt <= wq_cnt;
      endcase
    end
  end

  // Write-queue storage
  always_ff @(posedge clock) begin
    if (wq_push) wq_mem[wq_wp] <= data_wr;
  end

  // ---------------- read queue (FTDI -> host) ----------------
  logic [7:0]            rq_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rq_rp, rq_wp;
  logic [DEPTH_LOG2:0]   rq_cnt;
  logic                  rq_push, rq_pop;

  assign rdq_full  = (rq_cnt == FULL_CNT);
  assign rdq_empty = (rq_cnt == '0);
  assign rd_qsize  = rq_cnt;
  assign rq_pop    = rdreq & ~clear & ~rdq_empty;
  assign rq_push   = fsm_cap & ~clear & ~reset & (~rdq_full | rq_pop);

  // Read-queue pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rq_rp  <= '0;
      rq_wp  <= '0;
      rq_cnt <= '0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + 1'b1;
      if (rq_pop)  rq_rp <= rq_rp + 1'b1;
      unique case ({rq_push, rq_pop})
        2'b10:   rq_cnt <= rq_cnt + 1'b1;
        2'b01:   rq_cnt <= rq_cnt - 1'b1;
        default: rq_cnt <= rq_cnt;
      endcase
    end
  end

  // Read-queue storage, captured from the FTDI bus
  always_ff @(posedge clock) begin
    if (rq_push) rq_mem[rq_wp] <= adbus_in;
  end

  // Registered host read data and registered FTDI drive byte
  always_ff @(posedge clock) begin
    if (reset) begin
      data_rd   <= '0;
      adbus_out <= '0;
    end else begin
      if (rq_pop) data_rd   <= rq_mem[rq_rp];
      if (wq_pop) adbus_out <= wq_mem[wq_rp];
    end
  end

  // ---------------- transfer FSM ----------------
  assign rd_elig = rd_en & ~rxf_s & ~rdq_full;
  assign wr_elig = wr_en & ~txe_s & ~wrq_empty;

  // State register, per-state cycle counter and round-robin direction memory
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dir <= DIR_WR;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == IDLE && state_nx == WR_SETUP)  last_dir <= DIR_WR;
      else if (state == IDLE && state_nx == RD_LOW) last_dir <= DIR_RD;
    end
  end

  // Next-state, queue handshakes and strobe decode
  always_comb begin
    state_nx  = state;
    fsm_pop   = 1'b0;
    fsm_cap   = 1'b0;
    adbus_tri = 1'b0;
    ftdi_wr   = 1'b1;
    ftdi_rd   = 1'b1;
    unique case (state)
      IDLE: begin
        if (rd_elig && (!wr_elig || last_dir == DIR_WR)) begin
          state_nx = RD_LOW;
        end else if (wr_elig) begin
          state_nx = WR_SETUP;
          fsm_pop  = 1'b1;
        end
      end
      WR_SETUP: begin
        adbus_tri = 1'b1;
        if (cnt == WS_LAST) state_nx = WR_LOW;
      end
      WR_LOW: begin
        adbus_tri = 1'b1;
        ftdi_wr   = 1'b0;
        if (cnt == WL_LAST) state_nx = GAP;
      end
      RD_LOW: begin
        ftdi_rd = 1'b0;
        if (cnt == RL_LAST) begin
          fsm_cap  = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (cnt == GP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ftdi_async_bridge.sv
// Self-checking bench for ftdi_async_bridge: transaction-level reference model
// with a per-cycle compare, plus directed literal checks on two parameter sets.
module tb_ftdi_async_bridge;

  localparam int DEPTH = 1024;
  localparam int SYNC  = 2;
  localparam int SETUP = 1;
  localparam int WRLOW = 2;
  localparam int RDLOW = 2;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (defaults)
  logic        reset, clear, txe, rxf, wr_en, rd_en, wrreq, rdreq;
  logic [7:0]  data_wr, adbus_in, adbus_out, data_rd;
  logic        adbus_tri, ftdi_wr, ftdi_rd, rdq_full, rdq_empty, wrq_full, wrq_empty;
  logic [10:0] rd_qsize, wr_qsize;

  // DUT B (long read strobe, long gap)
  logic        clear_b, txe_b, rxf_b, wr_en_b, rd_en_b, wrreq_b, rdreq_b;
  logic [7:0]  data_wr_b, adbus_in_b, adbus_out_b, data_rd_b;
  logic        adbus_tri_b, ftdi_wr_b, ftdi_rd_b, rdq_full_b, rdq_empty_b, wrq_full_b, wrq_empty_b;
  logic [4:0]  rd_qsize_b, wr_qsize_b;

  ftdi_async_bridge dut_a (
    .clock(clk), .reset(reset), .clear(clear), .txe(txe), .rxf(rxf),
    .wr_en(wr_en), .rd_en(rd_en), .wrreq(wrreq), .data_wr(data_wr), .rdreq(rdreq),
    .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_tri(adbus_tri),
    .ftdi_wr(ftdi_wr), .ftdi_rd(ftdi_rd), .data_rd(data_rd),
    .rdq_full(rdq_full), .rdq_empty(rdq_empty), .wrq_full(wrq_full), .wrq_empty(wrq_empty),
    .rd_qsize(rd_qsize), .wr_qsize(wr_qsize)
  );

  ftdi_async_bridge #(.DEPTH_LOG2(4), .RD_LOW_CYC(4), .GAP_CYC(3)) dut_b (
    .clock(clk), .reset(reset), .clear(clear_b), .txe(txe_b), .rxf(rxf_b),
    .wr_en(wr_en_b), .rd_en(rd_en_b), .wrreq(wrreq_b), .data_wr(data_wr_b), .rdreq(rdreq_b),
    .adbus_in(adbus_in_b), .adbus_out(adbus_out_b), .adbus_tri(adbus_tri_b),
    .ftdi_wr(ftdi_wr_b), .ftdi_rd(ftdi_rd_b), .data_rd(data_rd_b),
    .rdq_full(rdq_full_b), .rdq_empty(rdq_empty_b), .wrq_full(wrq_full_b), .wrq_empty(wrq_empty_b),
    .rd_qsize(rd_qsize_b), .wr_qsize(wr_qsize_b)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model of DUT A ----------------
  // A transfer is a (kind, elapsed-cycle) pair; strobes follow from elapsed time.
  logic [7:0] m_rq[$];
  logic [7:0] m_wq[$];
  logic       m_txs[SYNC];
  logic       m_rxs[SYNC];
  int         m_kind = 0;   // 0 none, 1 write, 2 read
  int         m_t = 0;
  bit         m_last_wr = 1'b1;
  logic [7:0] m_out = '0;
  logic [7:0] m_drd = '0;

  always @(posedge clk) begin : model
    logic txs, rxs, rde, wre, cap;
    txs = m_txs[SYNC-1];
    rxs = m_rxs[SYNC-1];
    if (reset) begin
      m_rq.delete(); m_wq.delete();
      m_kind = 0; m_t = 0; m_last_wr = 1'b1; m_out = '0; m_drd = '0;
      for (int i = 0; i < SYNC; i++) begin m_txs[i] = 1'b1; m_rxs[i] = 1'b1; end
    end else begin
      if (clear) begin
        m_rq.delete(); m_wq.delete();
        m_kind = 0; m_t = 0;
      end else begin
        rde = rd_en && !rxs && (m_rq.size() < DEPTH);
        wre = wr_en && !txs && (m_wq.size() > 0);
        cap = 1'b0;
        if (m_kind == 0) begin
          if (rde && (!wre || m_last_wr)) begin
            m_kind = 2; m_t = 0; m_last_wr = 1'b0;
          end else if (wre) begin
            m_kind = 1; m_t = 0; m_last_wr = 1'b1; m_out = m_wq.pop_front();
          end
        end else begin
          if (m_kind == 2 && m_t == RDLOW - 1) cap = 1'b1;
          m_t++;
          if (m_t == ((m_kind == 1) ? SETUP + WRLOW + GAP : RDLOW + GAP)) begin
            m_kind = 0; m_t = 0;
          end
        end
        if (wrreq && m_wq.size() < DEPTH) m_wq.push_back(data_wr);
        if (rdreq && m_rq.size() > 0) m_drd = m_rq.pop_front();
        if (cap) m_rq.push_back(adbus_in);
      end
      for (int i = SYNC - 1; i > 0; i--) begin m_txs[i] = m_txs[i-1]; m_rxs[i] = m_rxs[i-1]; end
      m_txs[0] = txe;
      m_rxs[0] = rxf;
    end
  end

  // Per-cycle compare of DUT A against the model
  logic e_tri, e_wr, e_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      e_tri = (m_kind == 1) && (m_t < SETUP + WRLOW);
      e_wr  = !((m_kind == 1) && (m_t >= SETUP) && (m_t < SETUP + WRLOW));
      e_rd  = !((m_kind == 2) && (m_t < RDLOW));
      check("adbus_tri", adbus_tri, e_tri);
      check("ftdi_wr", ftdi_wr, e_wr);
      check("ftdi_rd", ftdi_rd, e_rd);
      check("adbus_out", adbus_out, m_out);
      check("data_rd", data_rd, m_drd);
      check("rd_qsize", rd_qsize, m_rq.size());
      check("wr_qsize", wr_qsize, m_wq.size());
      check("rdq_full", rdq_full, m_rq.size() == DEPTH);
      check("rdq_empty", rdq_empty, m_rq.size() == 0);
      check("wrq_full", wrq_full, m_wq.size() == DEPTH);
      check("wrq_empty", wrq_empty, m_wq.size() == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int exp_tri_pat[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
  int exp_wr_pat[11]  = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
  int exp_dir[4]      = '{1, 2, 1, 2};
  int seq[4];
  int guard, nst, lows;
  logic p_rd, p_tri;

  initial begin
    reset = 1'b1; clear = 1'b0; txe = 1'b1; rxf = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wrreq = 1'b0; rdreq = 1'b0; data_wr = '0; adbus_in = '0;
    clear_b = 1'b0; txe_b = 1'b1; rxf_b = 1'b1; wr_en_b = 1'b0; rd_en_b = 1'b0;
    wrreq_b = 1'b0; rdreq_b = 1'b0; data_wr_b = '0; adbus_in_b = '0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Reset state literals
    check("rst_ftdi_wr", ftdi_wr, 1);
    check("rst_ftdi_rd", ftdi_rd, 1);
    check("rst_adbus_tri", adbus_tri, 0);
    check("rst_adbus_out", adbus_out, 8'h00);
    check("rst_data_rd", data_rd, 8'h00);
    check("rst_rd_qsize", rd_qsize, 0);
    check("rst_wrq_empty", wrq_empty, 1);
    check("rst_rdq_full", rdq_full, 0);
    check("rst_model_rq", m_rq.size(), 0);

    // DUT B: 4-cycle read strobe, 3 gap cycles, capture on the 4th low cycle
    rd_en_b = 1'b1;
    rxf_b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      adbus_in_b = 8'(8'h30 + k);
      tick(1);
      check("b_ftdi_rd", ftdi_rd_b, !((k >= 3 && k <= 6) || (k >= 11 && k <= 14)));
      check("b_adbus_tri", adbus_tri_b, 0);
      if (k == 12) rxf_b = 1'b1;
    end
    check("b_rd_qsize", rd_qsize_b, 2);
    rdreq_b = 1'b1;
    tick(1);
    check("b_data_rd_0", data_rd_b, 8'h37);
    tick(1);
    rdreq_b = 1'b0;
    check("b_data_rd_1", data_rd_b, 8'h3F);
    check("b_rdq_empty", rdq_empty_b, 1);
    rd_en_b = 1'b0;

    // Single read: strobe low after the 3rd edge for 2 cycles
    rd_en = 1'b1; rxf = 1'b0; adbus_in = 8'hA5;
    tick(2);
    check("r36_rd_e2", ftdi_rd, 1);
    tick(1);
    check("r36_rd_e3", ftdi_rd, 0);
    rxf = 1'b1;
    tick(1);
    check("r36_rd_e4", ftdi_rd, 0);
    check("r36_qsize_e4", rd_qsize, 0);
    tick(1);
    check("r36_rd_e5", ftdi_rd, 1);
    check("r36_qsize_e5", rd_qsize, 1);
    check("r36_model_rq", m_rq.size(), 1);
    tick(3);
    rdreq = 1'b1;
    tick(1);
    rdreq = 1'b0;
    check("r36_data_rd", data_rd, 8'hA5);
    check("r36_qsize_pop", rd_qsize, 0);
    rd_en = 1'b0;
    tick(2);

    // Two-byte write: setup / low / gap / idle per byte
    wr_en = 1'b1;
    wrreq = 1'b1; data_wr = 8'h11; tick(1);
    data_wr = 8'h22; tick(1);
    wrreq = 1'b0;
    check("r37_wr_qsize", wr_qsize, 2);
    check("r37_model_wq", m_wq.size(), 2);
    txe = 1'b0;
    guard = 0;
    while (adbus_tri !== 1'b1 && guard < 20) begin tick(1); guard++; end
    check("r37_start", adbus_tri, 1);
    for (int j = 0; j < 11; j++) begin
      check("r37_tri", adbus_tri, exp_tri_pat[j]);
      check("r37_wr", ftdi_wr, exp_wr_pat[j]);
      if (j <= 2) check("r37_out0", adbus_out, 8'h11);
      if (j >= 6 && j <= 8) check("r37_out1", adbus_out, 8'h22);
      if (j < 10) tick(1);
    end
    check("r37_wrq_empty", wrq_empty, 1);
    txe = 1'b1; wr_en = 1'b0;
    tick(4);

    // Clear during the write strobe, with a simultaneous push that must lose
    wr_en = 1'b1;
    wrreq = 1'b1;
    for (int j = 0; j < 6; j++) begin data_wr = 8'(8'h60 + j); tick(1); end
    wrreq = 1'b0;
    txe = 1'b0;
    guard = 0;
    while (ftdi_wr !== 1'b0 && guard < 20) begin tick(1); guard++; end
    check("r40_wr_low", ftdi_wr, 0);
    check("r40_qsize", wr_qsize, 5);
    clear = 1'b1; wrreq = 1'b1; data_wr = 8'hEE;
    tick(1);
    clear = 1'b0; wrreq = 1'b0;
    check("r40_ftdi_wr", ftdi_wr, 1);
    check("r40_tri", adbus_tri, 0);
    check("r40_qsize_clr", wr_qsize, 0);
    txe = 1'b1; wr_en = 1'b0;
    tick(4);

    // Round-robin with both directions ready; last service was a write
    wrreq = 1'b1;
    for (int j = 0; j < 3; j++) begin data_wr = 8'(8'hC0 + j); tick(1); end
    wrreq = 1'b0;
    for (int j = 0; j < 4; j++) seq[j] = 0;
    rd_en = 1'b1; wr_en = 1'b1; txe = 1'b0; rxf = 1'b0;
    p_rd = ftdi_rd; p_tri = adbus_tri; nst = 0;
    for (int c = 0; c < 80 && nst < 4; c++) begin
      adbus_in = 8'($urandom);
      tick(1);
      if (p_rd && !ftdi_rd) begin seq[nst] = 1; nst++; end
      else if (!p_tri && adbus_tri) begin seq[nst] = 2; nst++; end
      p_rd = ftdi_rd; p_tri = adbus_tri;
    end
    check("r38_count", nst, 4);
    for (int j = 0; j < 4; j++) check("r38_dir", seq[j], exp_dir[j]);
    rd_en = 1'b0; wr_en = 1'b0; txe = 1'b1; rxf = 1'b1;
    tick(10);

    // Fill the read queue; no reads while full, exactly one after one pop
    rd_en = 1'b1; rxf = 1'b0;
    guard = 0;
    while (rdq_full !== 1'b1 && guard < 6000) begin adbus_in = 8'($urandom); tick(1); guard++; end
    check("r39_full", rdq_full, 1);
    check("r39_qsize", rd_qsize, 1024);
    lows = 0;
    for (int c = 0; c < 20; c++) begin tick(1); if (!ftdi_rd) lows++; end
    check("r39_idle_lows", lows, 0);
    rdreq = 1'b1;
    tick(1);
    rdreq = 1'b0;
    if (!ftdi_rd) lows++;
    for (int c = 0; c < 20; c++) begin tick(1); if (!ftdi_rd) lows++; end
    check("r39_one_read", lows, 2);
    check("r39_full_again", rdq_full, 1);
    rd_en = 1'b0; rxf = 1'b1;
    clear = 1'b1; tick(1); clear = 1'b0;
    tick(4);

    // Fill the write queue; push-on-full ignored, push+pop on full both happen
    wrreq = 1'b1;
    for (int c = 0; c < 1030; c++) begin data_wr = 8'($urandom); tick(1); end
    check("wq_full", wrq_full, 1);
    check("wq_qsize", wr_qsize, 1024);
    wr_en = 1'b1; txe = 1'b0;
    for (int c = 0; c < 40; c++) begin data_wr = 8'($urandom); tick(1); end
    check("wq_full_hold", wrq_full, 1);
    wrreq = 1'b0; wr_en = 1'b0; txe = 1'b1;
    tick(8);
    clear = 1'b1; tick(1); clear = 1'b0;
    tick(4);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 599) == 0);
      clear    = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) txe = ~txe;
      if ($urandom_range(0, 7) == 0) rxf = ~rxf;
      wr_en    = ($urandom_range(0, 3) != 0);
      rd_en    = ($urandom_range(0, 3) != 0);
      wrreq    = ($urandom_range(0, 2) == 0);
      rdreq    = ($urandom_range(0, 2) == 0);
      data_wr  = 8'($urandom);
      adbus_in = 8'($urandom);
      tick(1);
    end
    reset = 1'b0; clear = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
